// File: rtl/sum_uart_framer_if.sv
// Handshake bundle between the sum source and the UART framer.
// Master drives the request side, slave drives the serial line.
interface sum_uart_framer_if #(
  parameter int bits = 5
);
  logic [bits-1:0] sum_in;
  logic            send;
  logic            uart_tx_en;
  logic            uart_txd;
  logic            uart_tx_busy;

  modport master (
    output sum_in,
    output send,
    output uart_tx_en,
    input  uart_txd,
    input  uart_tx_busy
  );

  modport slave (
    input  sum_in,
    input  send,
    input  uart_tx_en,
    output uart_txd,
    output uart_tx_busy
  );
endinterface

// File: rtl/sum_uart_framer.sv
// Sends a latched sum as "TO\r\n" (two ASCII decimal digits, CR, LF)
// over an 8N1 UART line, LSB first, idle high.
module sum_uart_framer #(
  parameter int bits     = 5,
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic             clk,
  input  logic             reset,
  sum_uart_framer_if.slave bus
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [bits-1:0] sum_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      byte_idx;
  logic [2:0]      bit_idx;
  logic [2:0]      nxt_bit;
  logic            txd_q;
  logic            busy_q;
  logic            bit_end;
  logic [5:0]      s6;
  logic [3:0]      tens;
  logic [3:0]      ones;
  logic [7:0]      cur_byte;

  assign bus.uart_txd     = txd_q;
  assign bus.uart_tx_busy = busy_q;

  assign bit_end = (cnt == CNT_MAX);
  assign nxt_bit = bit_idx + 3'd1;
  assign s6      = 6'(sum_q);

  // Exact decimal split of a value up to 63 by range compare.
  always_comb begin
    tens = 4'd0;
    if (s6 >= 6'd60)      tens = 4'd6;
    else if (s6 >= 6'd50) tens = 4'd5;
    else if (s6 >= 6'd40) tens = 4'd4;
    else if (s6 >= 6'd30) tens = 4'd3;
    else if (s6 >= 6'd20) tens = 4'd2;
    else if (s6 >= 6'd10) tens = 4'd1;
    ones = 4'(s6 - (6'(tens) * 6'd10));
  end

  // Byte currently on the wire; stable for a whole byte.
  always_comb begin
    cur_byte = 8'h0A;
    unique case (byte_idx)
      2'd0: cur_byte = {4'h3, tens};
      2'd1: cur_byte = {4'h3, ones};
      2'd2: cur_byte = 8'h0D;
      2'd3: cur_byte = 8'h0A;
    endcase
  end

  // Framer FSM with baud timing and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sum_q    <= '0;
      cnt      <= '0;
      byte_idx <= 2'd0;
      bit_idx  <= 3'd0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
          if (bus.send && bus.uart_tx_en) begin
            sum_q    <= bus.sum_in;
            cnt      <= '0;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            txd_q   <= cur_byte[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= nxt_bit;
              txd_q   <= cur_byte[nxt_bit];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (byte_idx == 2'd3) begin
              byte_idx <= 2'd0;
              txd_q    <= 1'b1;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              txd_q    <= 1'b0;
              state    <= START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_framer.sv
// Directed bench for sum_uart_framer, DIV=16.
// Line and busy are logged per cycle, then decoded at bit centres.
module tb_sum_uart_framer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sum_uart_framer_if #(.bits(5)) bus5 ();
  sum_uart_framer_if #(.bits(6)) bus6 ();

  sum_uart_framer #(
    .bits(5),
    .CLK_FREQ(16),
    .BAUD(1)
  ) dut5 (
    .clk(clk),
    .reset(reset),
    .bus(bus5.slave)
  );

  sum_uart_framer #(
    .bits(6),
    .CLK_FREQ(16),
    .BAUD(1)
  ) dut6 (
    .clk(clk),
    .reset(reset),
    .bus(bus6.slave)
  );

  int checks = 0;
  int failures = 0;
  logic txd_log [0:1399];
  logic busy_log [0:1399];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Log n cycles; optional mid-message send pulse, enable drop, reset.
  task automatic capture(input int n, input int which,
                         input int pulse_at, input logic [4:0] new_sum,
                         input int en_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == pulse_at) begin
        bus5.send = 1'b1;
        bus5.sum_in = new_sum;
      end
      if (i == pulse_at + 1) bus5.send = 1'b0;
      if (i == en_at) bus5.uart_tx_en = 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        chk("async_rst_txd", 32'(bus5.uart_txd), 32'd1);
        chk("async_rst_busy", 32'(bus5.uart_tx_busy), 32'd0);
      end
      if (i == rst_at + 1) reset = 1'b0;
      txd_log[i] = (which != 0) ? bus6.uart_txd : bus5.uart_txd;
      busy_log[i] = (which != 0) ? bus6.uart_tx_busy : bus5.uart_tx_busy;
    end
  endtask

  task automatic chk_msg(input string tag, input int base,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp [4];
    logic [7:0] d;
    logic st;
    logic sp;
    exp = '{b0, b1, b2, b3};
    for (int b = 0; b < 4; b++) begin
      st = txd_log[base + b * 160 + 8];
      for (int j = 0; j < 8; j++)
        d[j] = txd_log[base + b * 160 + (j + 1) * 16 + 8];
      sp = txd_log[base + b * 160 + 9 * 16 + 8];
      chk({tag, "_data"}, 32'(d), 32'(exp[b]));
      chk({tag, "_frame"}, {30'd0, sp, st}, 32'd2);
    end
  endtask

  task automatic chk_idle(input string tag, input int from, input int to);
    int zeros;
    int busys;
    zeros = 0;
    busys = 0;
    for (int i = from; i <= to; i++) begin
      if (txd_log[i] !== 1'b1) zeros++;
      if (busy_log[i] !== 1'b0) busys++;
    end
    chk({tag, "_txd_low"}, 32'(zeros), 32'd0);
    chk({tag, "_busy"}, 32'(busys), 32'd0);
  endtask

  task automatic chk_busy(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 700; i++)
      if (busy_log[i] === 1'b1) cnt++;
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd640);
    chk({tag, "_busy_first"}, 32'(busy_log[0]), 32'd1);
    chk({tag, "_start_low"}, 32'(txd_log[0]), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy_log[640]), 32'd0);
  endtask

  // One-cycle send; the accepting edge is the posedge inside.
  task automatic start_msg(input logic [4:0] s);
    @(posedge clk);
    #1;
    bus5.sum_in = s;
    bus5.send = 1'b1;
    @(posedge clk);
    #1;
    bus5.send = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus5.sum_in = '0;
    bus5.send = 1'b0;
    bus5.uart_tx_en = 1'b1;
    bus6.sum_in = '0;
    bus6.send = 1'b0;
    bus6.uart_tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_txd", 32'(bus5.uart_txd), 32'd1);
    chk("reset_busy", 32'(bus5.uart_tx_busy), 32'd0);
    chk("reset_txd6", 32'(bus6.uart_txd), 32'd1);
    reset = 1'b0;

    start_msg(5'd23);
    capture(700, 0, -1, 5'd0, -1, -1);
    chk_msg("sum23", 0, 8'h32, 8'h33, 8'h0D, 8'h0A);
    chk_busy("sum23");
    chk_idle("sum23_tail", 640, 699);

    start_msg(5'd0);
    capture(700, 0, -1, 5'd0, -1, -1);
    chk_msg("sum0", 0, 8'h30, 8'h30, 8'h0D, 8'h0A);
    start_msg(5'd31);
    capture(700, 0, -1, 5'd0, -1, -1);
    chk_msg("sum31", 0, 8'h33, 8'h31, 8'h0D, 8'h0A);
    chk_busy("sum31");

    start_msg(5'd5);
    capture(700, 0, 100, 5'd17, -1, -1);
    chk_msg("drop_req", 0, 8'h30, 8'h35, 8'h0D, 8'h0A);
    chk_busy("drop_req");
    chk_idle("drop_req_tail", 640, 699);

    bus5.uart_tx_en = 1'b0;
    start_msg(5'd12);
    capture(60, 0, -1, 5'd0, -1, -1);
    chk_idle("en_low", 0, 59);
    bus5.uart_tx_en = 1'b1;

    start_msg(5'd12);
    capture(700, 0, -1, 5'd0, 200, -1);
    chk_msg("en_drop", 0, 8'h31, 8'h32, 8'h0D, 8'h0A);
    chk_busy("en_drop");
    bus5.uart_tx_en = 1'b1;

    start_msg(5'd27);
    capture(700, 0, -1, 5'd0, -1, 250);
    chk_idle("after_rst", 251, 699);
    start_msg(5'd9);
    capture(700, 0, -1, 5'd0, -1, -1);
    chk_msg("sum9", 0, 8'h30, 8'h39, 8'h0D, 8'h0A);
    chk_busy("sum9");

    @(posedge clk);
    #1;
    bus6.sum_in = 6'd63;
    bus6.send = 1'b1;
    @(posedge clk);
    capture(1300, 1, -1, 5'd0, -1, -1);
    bus6.send = 1'b0;
    chk_msg("sum63a", 0, 8'h36, 8'h33, 8'h0D, 8'h0A);
    chk_msg("sum63b", 641, 8'h36, 8'h33, 8'h0D, 8'h0A);
    chk("b2b_gap_busy", 32'(busy_log[640]), 32'd0);
    chk("b2b_restart_busy", 32'(busy_log[641]), 32'd1);
    chk("b2b_restart_txd", 32'(txd_log[641]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
